pc_ras_unit: RTL
================

# pc_ras_unit

Parametrised program-counter unit for the fetch stage: holds the fetch address and advances it by a fixed increment each cycle. It supports stall, conditional branch, call and return, and keeps an internal return-address stack (RAS) of configurable depth. It replaces the fixed 12-bit branch/hold counter and feeds the instruction-memory address and the decode-stage PC.

## Interface
- PC_WIDTH, 12, width of all addresses
- RAS_DEPTH, 4, number of return-address entries (≥1)
- RESET_VECTOR, 0, value loaded into pc on reset
- PC_INC, 1, increment applied on sequential advance
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- stall  input  1  hold pc and RAS unchanged
- branch_en  input  1  redirect to branch_target
- branch_target  input  PC_WIDTH  branch destination
- call_en  input  1  push return address, redirect to call_target
- call_target  input  PC_WIDTH  call destination
- ret_en  input  1  pop RAS, redirect to popped address
- err_clr  input  1  clear sticky error flags
- pc  output  PC_WIDTH  current fetch address (registered)
- ras_count  output  $clog2(RAS_DEPTH+1)  valid entries in RAS
- ras_full  output  1  ras_count == RAS_DEPTH
- ras_empty  output  1  ras_count == 0
- ras_ovf  output  1  sticky: a call occurred while full
- ras_unf  output  1  sticky: a return occurred while empty

## Operation
- Reset: pc=RESET_VECTOR, ras_count=0, ras_ovf=0, ras_unf=0. Stack contents are don't-care. ras_empty=1, ras_full=0.
- Per-cycle action priority, highest first: reset > stall > ret_en > call_en > branch_en > sequential. Exactly one action is taken per cycle.
- stall: pc, stack, and ras_count are held. All control inputs are ignored. err_clr is still honoured.
- ret_en with ras_count>0: pc ← top entry, ras_count −1.
- ret_en with ras_count==0: pc ← pc+PC_INC, stack unchanged, ras_unf ← 1.
- call_en: push pc+PC_INC, then pc ← call_target.
  - Not full: ras_count +1.
  - Full: the oldest entry is overwritten (circular buffer), ras_count stays RAS_DEPTH, ras_ovf ← 1.
- branch_en: pc ← branch_target. RAS unchanged.
- Sequential: pc ← pc+PC_INC.
- Arithmetic is modulo 2^PC_WIDTH. pc+PC_INC wraps silently, including for the pushed return address.
- Stack organisation: circular buffer with top pointer. Push writes at top+1 and pop reads top, both mod RAS_DEPTH. After an overflow, popping RAS_DEPTH times returns the newest RAS_DEPTH return addresses in LIFO order.
- Sticky flags: set and err_clr in the same cycle → the set wins. err_clr alone clears both flags.

## Timing
- All outputs are registered. A redirect asserted in cycle N appears on pc at cycle N+1. There are no combinational paths from inputs to outputs.
- Return latency is 1 cycle. A call in cycle N followed by ret in cycle N+1 returns to the pushed address in cycle N+2.
- ras_full, ras_empty, and ras_count reflect state after the last edge. A push and pop can never occur in the same cycle.
- Reset asserted mid-sequence (e.g. during nested calls) discards the whole stack on that edge.
- Control inputs must be stable around the clk edge. Pulse width is one cycle per action; a held signal repeats its action each cycle.

## Test plan
- Reset and sequential (RESET_VECTOR=0, PC_INC=1): assert reset, release it, run 5 cycles → pc=0,1,2,3,4,5; ras_empty=1; flags 0.
- Wrap and stall: force pc to 0xFFE, run 1 cycle → 0xFFF. Next cycle with stall=1 → pc holds 0xFFF. Release stall → pc=0x000.
- Priority: at pc=0x010, assert branch_en(0x100), call_en(0x200), ret_en together with an empty RAS → pc=0x011 and ras_unf=1. Repeat with stall=1 → pc unchanged and no flag change.
- Nested call/return: call 0x100 at pc=0x010, then call 0x200 at pc=0x100 → ras_count=2. Ret → pc=0x101. Ret → pc=0x011, and ras_empty=1.
- Overflow (RAS_DEPTH=4): 5 consecutive calls from pc values A0..A4 → ras_ovf=1 and ras_count=4. Four returns yield A4+1, A3+1, A2+1, A1+1. A fifth return → pc increments and ras_unf=1.
- Error clear and reset mid-operation:
  - err_clr coinciding with an underflow → ras_unf stays 1; err_clr on the next cycle → both flags 0.
  - Reset after 2 calls → pc=RESET_VECTOR and ras_count=0 on the next edge.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with call/return support.
// Keeps the fetch address and a circular return-address stack. Each cycle
// exactly one action is taken, in this priority order:
// reset > stall > return > call > branch > sequential advance.
module pc_ras_unit #(
  parameter int PC_WIDTH     = 12,
  parameter int RAS_DEPTH    = 4,
  parameter int RESET_VECTOR = 0,
  parameter int PC_INC       = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch_en,
  input  logic [PC_WIDTH-1:0]            branch_target,
  input  logic                           call_en,
  input  logic [PC_WIDTH-1:0]            call_target,
  input  logic                           ret_en,
  input  logic                           err_clr,
  output logic [PC_WIDTH-1:0]            pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  // A one-entry stack still needs a one-bit pointer to index the array.
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [PC_WIDTH-1:0] INC       = PC_WIDTH'(PC_INC);
  localparam logic [PC_WIDTH-1:0] RST_PC    = PC_WIDTH'(RESET_VECTOR);
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(RAS_DEPTH - 1);

  // Pointer arithmetic modulo RAS_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_prev(input logic [PTR_W-1:0] p);
    if (p == '0) return PTR_LAST;
    return p - 1'b1;
  endfunction

  // Stack storage is data only; its contents are don't-care after reset.
  logic [PC_WIDTH-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0]    top;

  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PTR_W-1:0]    top_next;
  logic [CNT_W-1:0]    count_next;
  logic                push;
  logic                ovf_set;
  logic                unf_set;
  logic                ovf_next;
  logic                unf_next;

  // Select the single action for this cycle and form the next state.
  always_comb begin
    pc_seq     = pc + INC;
    pc_next    = pc_seq;
    top_next   = top;
    count_next = ras_count;
    push       = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (ret_en) begin
      if (ras_count != '0) begin
        pc_next    = stack[top];
        top_next   = ptr_prev(top);
        count_next = ras_count - 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (call_en) begin
      push     = 1'b1;
      pc_next  = call_target;
      top_next = ptr_next(top);
      if (ras_count == CNT_MAX) ovf_set = 1'b1;
      else                      count_next = ras_count + 1'b1;
    end else if (branch_en) begin
      pc_next = branch_target;
    end
    // A flag being set outranks a simultaneous clear.
    ovf_next = ovf_set | (ras_ovf & ~err_clr);
    unf_next = unf_set | (ras_unf & ~err_clr);
  end

  // Control state: pc, stack pointer, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RST_PC;
      top       <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else begin
      pc        <= pc_next;
      top       <= top_next;
      ras_count <= count_next;
      ras_ovf   <= ovf_next;
      ras_unf   <= unf_next;
    end
  end

  // Return-address write: on overflow this lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (push && !reset) stack[top_next] <= pc_seq;
  end

  assign ras_full  = (ras_count == CNT_MAX);
  assign ras_empty = (ras_count == '0);

endmodule
